ram_dp_be: RTL

Parametrised true dual-port single-clock RAM with per-byte write enables, configurable output register, read-valid flags and a post-reset clear sequencer. Successor to the plain dual-port RAM macro wrapper: inferred storage instead of a vendor primitive, with defined read-during-write semantics and a `busy` indication while the array is being zeroed. Sits between the core's load/store units and the data/register memories.

---
 rtl/ram_dp_be_if.sv | 34 +++
 rtl/ram_dp_be.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ram_dp_be_if.sv
// Request/response bundle for both ports of ram_dp_be.
// The master issues address, write and read requests; the slave returns read data with a valid pulse.
interface ram_dp_be_if #(
  parameter int WIDTHAD = 10,
  parameter int WIDTH   = 32
);
  logic [WIDTHAD-1:0] address_a;
  logic               wren_a;
  logic [WIDTH/8-1:0] byteena_a;
  logic [WIDTH-1:0]   data_a;
  logic               rden_a;
  logic [WIDTH-1:0]   q_a;
  logic               qvalid_a;

  logic [WIDTHAD-1:0] address_b;
  logic               wren_b;
  logic [WIDTH/8-1:0] byteena_b;
  logic [WIDTH-1:0]   data_b;
  logic               rden_b;
  logic [WIDTH-1:0]   q_b;
  logic               qvalid_b;

  modport master (
    output address_a, wren_a, byteena_a, data_a, rden_a,
    output address_b, wren_b, byteena_b, data_b, rden_b,
    input  q_a, qvalid_a, q_b, qvalid_b
  );

  modport slave (
    input  address_a, wren_a, byteena_a, data_a, rden_a,
    input  address_b, wren_b, byteena_b, data_b, rden_b,
    output q_a, qvalid_a, q_b, qvalid_b
  );
endinterface

// File: rtl/ram_dp_be.sv
// True dual-port byte-enable RAM with zeroing sweep after reset; read latency 1 (OUTREG=0) or 2 (OUTREG=1).
// No backpressure: every request is taken in READY, every request is dropped while busy.
module ram_dp_be #(
  parameter int WIDTHAD        = 10,
  parameter int WIDTH          = 32,
  parameter int OUTREG         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  ram_dp_be_if.slave    bus
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << WIDTHAD;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTHAD-1:0] clr_addr_q, clr_addr_d;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               acc_wr_a, acc_wr_b;
  logic               acc_rd_a, acc_rd_b;
  logic [WIDTH-1:0]   rd_word_a, rd_word_b;

  logic               rd_vld_a_q, rd_vld_b_q;
  logic [WIDTH-1:0]   rd_dat_a_q, rd_dat_b_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {WIDTHAD{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  assign acc_wr_a = bus.wren_a & ~busy;
  assign acc_wr_b = bus.wren_b & ~busy;
  assign acc_rd_a = bus.rden_a & ~busy;
  assign acc_rd_b = bus.rden_b & ~busy;

  // ---------------------------------------------------------------- storage
  // Port B bytes are written first so port A's later assignment wins on overlap.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (acc_wr_b && bus.byteena_b[i]) begin
          mem[bus.address_b][8*i +: 8] <= bus.data_b[8*i +: 8];
        end
        if (acc_wr_a && bus.byteena_a[i]) begin
          mem[bus.address_a][8*i +: 8] <= bus.data_a[8*i +: 8];
        end
      end
    end
  end

  // Own-port write bytes bypass into the read word; the other port's write stays invisible.
  always_comb begin
    rd_word_a = mem[bus.address_a];
    rd_word_b = mem[bus.address_b];
    for (int i = 0; i < NB; i++) begin
      if (acc_wr_a && bus.byteena_a[i]) begin
        rd_word_a[8*i +: 8] = bus.data_a[8*i +: 8];
      end
      if (acc_wr_b && bus.byteena_b[i]) begin
        rd_word_b[8*i +: 8] = bus.data_b[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_a_q <= 1'b0;
      rd_vld_b_q <= 1'b0;
      rd_dat_a_q <= '0;
      rd_dat_b_q <= '0;
    end else begin
      rd_vld_a_q <= acc_rd_a;
      rd_vld_b_q <= acc_rd_b;
      if (acc_rd_a) begin
        rd_dat_a_q <= rd_word_a;
      end
      if (acc_rd_b) begin
        rd_dat_b_q <= rd_word_b;
      end
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic             out_vld_a_q, out_vld_b_q;
      logic [WIDTH-1:0] out_dat_a_q, out_dat_b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld_a_q <= 1'b0;
          out_vld_b_q <= 1'b0;
          out_dat_a_q <= '0;
          out_dat_b_q <= '0;
        end else begin
          out_vld_a_q <= rd_vld_a_q;
          out_vld_b_q <= rd_vld_b_q;
          if (rd_vld_a_q) begin
            out_dat_a_q <= rd_dat_a_q;
          end
          if (rd_vld_b_q) begin
            out_dat_b_q <= rd_dat_b_q;
          end
        end
      end

      assign bus.q_a      = out_dat_a_q;
      assign bus.q_b      = out_dat_b_q;
      assign bus.qvalid_a = out_vld_a_q;
      assign bus.qvalid_b = out_vld_b_q;
    end else begin : g_direct
      assign bus.q_a      = rd_dat_a_q;
      assign bus.q_b      = rd_dat_b_q;
      assign bus.qvalid_a = rd_vld_a_q;
      assign bus.qvalid_b = rd_vld_b_q;
    end
  endgenerate

endmodule
